// File: rtl/mmio_test_mailbox_pkg.sv
// rtl/mmio_test_mailbox_pkg.sv - shared state encoding and register offsets for the test mailbox
package mmio_test_mailbox_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } mbox_state_t;

    localparam logic [3:0] OFF_RESULT  = 4'h0;
    localparam logic [3:0] OFF_CKPT    = 4'h4;
    localparam logic [3:0] OFF_CYCLES  = 4'h8;
    localparam logic [3:0] OFF_SCRATCH = 4'hC;

endpackage

// File: rtl/mailbox_watchdog.sv
// rtl/mailbox_watchdog.sv - saturating run-cycle counter with expiry compare
module mailbox_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] cycles,
    output logic        expired
);

    localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (en && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // Expiry fires on the edge that carries the count up to TIMEOUT_CYCLES.
    assign cycles  = r_cycles;
    assign expired = en && (r_cycles == LIMIT);

endmodule

// File: rtl/mmio_test_mailbox.sv
// rtl/mmio_test_mailbox.sv - memory-mapped PASS/FAIL/checkpoint mailbox with watchdog for test programs
module mmio_test_mailbox
    import mmio_test_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0F00,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [31:0] PASS_MAGIC     = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic [1:0]  state,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_code,
    output logic [31:0] checkpoint,
    output logic [31:0] cycles
);

    mbox_state_t r_state;
    logic [15:0] r_fail_code;
    logic [31:0] r_checkpoint;
    logic [7:0]  r_ckpt_count;
    logic [31:0] r_scratch;

    logic [31:0] w_off;
    logic [3:0]  w_sel;
    logic        w_hit;
    logic        w_run;
    logic        w_wr;
    logic        w_result_wr;
    logic        w_ckpt_wr;
    logic        w_scratch_wr;
    logic [31:0] w_cycles;
    logic        w_expired;

    // Subtracting first keeps the window test correct for bases that are not 16-byte aligned.
    assign w_off = DataAdr - BASE_ADDR;
    assign w_sel = w_off[3:0];
    assign w_hit = (w_off < 32'd16) && (DataAdr[1:0] == 2'b00);
    assign w_run = (r_state == ST_RUN);
    assign w_wr  = MemWrite && w_hit;

    assign w_result_wr  = w_wr && w_run && (w_sel == OFF_RESULT) && (WriteData != 32'd0);
    assign w_ckpt_wr    = w_wr && w_run && (w_sel == OFF_CKPT);
    assign w_scratch_wr = w_wr && (w_sel == OFF_SCRATCH);

    mailbox_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .en     (w_run),
        .cycles (w_cycles),
        .expired(w_expired)
    );

    // A verdict written on the expiry edge takes priority over the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_fail_code <= '0;
        end else if (w_result_wr) begin
            if (WriteData == PASS_MAGIC) begin
                r_state <= ST_PASS;
            end else begin
                r_state     <= ST_FAIL;
                r_fail_code <= WriteData[15:0];
            end
        end else if (w_expired) begin
            r_state <= ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checkpoint <= '0;
            r_ckpt_count <= '0;
        end else if (w_ckpt_wr) begin
            r_checkpoint <= WriteData;
            if (r_ckpt_count != 8'hFF) begin
                r_ckpt_count <= r_ckpt_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scratch <= '0;
        end else if (w_scratch_wr) begin
            r_scratch <= WriteData;
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (w_hit) begin
            case (w_sel)
                OFF_RESULT:  ReadData = {30'd0, r_state};
                OFF_CKPT:    ReadData = {r_ckpt_count, r_checkpoint[23:0]};
                OFF_CYCLES:  ReadData = w_cycles;
                OFF_SCRATCH: ReadData = r_scratch;
                default:     ReadData = 32'd0;
            endcase
        end
    end

    assign hit        = w_hit;
    assign state      = r_state;
    assign done       = (r_state != ST_RUN);
    assign pass       = (r_state == ST_PASS);
    assign fail_code  = r_fail_code;
    assign checkpoint = r_checkpoint;
    assign cycles     = w_cycles;

endmodule

// File: tb/tb_mmio_test_mailbox.sv
// tb/tb_mmio_test_mailbox.sv - randomized self-checking bench for mmio_test_mailbox
module tb_mmio_test_mailbox;

    localparam logic [31:0] BASE  = 32'h0000_0F00;
    localparam int unsigned TO    = 1000;
    localparam logic [31:0] MAGIC = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr = 32'd0;
    logic [31:0] wd = 32'd0;
    logic        we = 1'b0;
    logic [31:0] rd;
    logic        hit;
    logic [1:0]  state;
    logic        done;
    logic        pass;
    logic [15:0] fail_code;
    logic [31:0] checkpoint;
    logic [31:0] cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  m_state;
    logic [31:0] m_cycles;
    logic [31:0] m_ckpt;
    logic [7:0]  m_cnt;
    logic [31:0] m_scr;
    logic [15:0] m_fail;

    mmio_test_mailbox #(
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TO),
        .PASS_MAGIC    (MAGIC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .DataAdr   (adr),
        .WriteData (wd),
        .MemWrite  (we),
        .ReadData  (rd),
        .hit       (hit),
        .state     (state),
        .done      (done),
        .pass      (pass),
        .fail_code (fail_code),
        .checkpoint(checkpoint),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_hit(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd12) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_hit(a)) return 32'd0;
        case (a - BASE)
            32'd0:   return {30'd0, m_state};
            32'd4:   return {m_cnt, m_ckpt[23:0]};
            32'd8:   return m_cycles;
            default: return m_scr;
        endcase
    endfunction

    task automatic model_reset();
        m_state  = 2'd0;
        m_cycles = 32'd0;
        m_ckpt   = 32'd0;
        m_cnt    = 8'd0;
        m_scr    = 32'd0;
        m_fail   = 16'd0;
    endtask

    task automatic model_update(input logic [31:0] a, input logic [31:0] d, input logic w);
        logic        wr;
        logic [31:0] off;
        wr  = w && model_hit(a);
        off = a - BASE;
        if (m_state == 2'd0) begin
            if (wr && off == 32'd0 && d != 32'd0) begin
                if (d == MAGIC) begin
                    m_state = 2'd1;
                end else begin
                    m_state = 2'd2;
                    m_fail  = d[15:0];
                end
            end else if (m_cycles + 32'd1 == TO) begin
                m_state = 2'd3;
            end
            if (wr && off == 32'd4) begin
                m_ckpt = d;
                if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
            end
            if (m_cycles < 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
        end
        if (wr && off == 32'd12) m_scr = d;
    endtask

    task automatic check_outs();
        chk("state", {30'd0, state}, {30'd0, m_state});
        chk("done", {31'd0, done}, {31'd0, (m_state != 2'd0)});
        chk("pass", {31'd0, pass}, {31'd0, (m_state == 2'd1)});
        chk("fail_code", {16'd0, fail_code}, {16'd0, m_fail});
        chk("checkpoint", checkpoint, m_ckpt);
        chk("cycles", cycles, m_cycles);
    endtask

    // Called right after a falling edge; returns right after the next falling edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
        adr = a;
        wd  = d;
        we  = w;
        #1;
        chk("hit", {31'd0, hit}, {31'd0, model_hit(a)});
        chk("rdata", rd, model_read(a));
        @(posedge clk);
        model_update(a, d, w);
        #1;
        check_outs();
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp_rd,
                        input logic exp_hit);
        adr = a;
        we  = 1'b0;
        #1;
        chk(tag, rd, exp_rd);
        chk({tag, "_hit"}, {31'd0, hit}, {31'd0, exp_hit});
        @(posedge clk);
        model_update(a, 32'd0, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we    = 1'b0;
        #2;
        model_reset();
        check_outs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step($urandom, $urandom, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return BASE;
            1:       return BASE + 32'd4;
            2:       return BASE + 32'd8;
            3:       return BASE + 32'd12;
            4:       return BASE + 32'd2;
            5:       return BASE + 32'd16;
            6:       return BASE - 32'd4;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 32'd1;
            1:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        do_reset();

        // T1 idle run
        idle(20);
        chk("t1_cycles", cycles, 32'd20);
        chk("t1_done", {31'd0, done}, 32'd0);
        peek("t1_rd_cycles", BASE + 32'd8, 32'd20, 1'b1);

        // T2 PASS at cycle 5
        do_reset();
        idle(5);
        step(BASE, 32'd1, 1'b1);
        chk("t2_pass", {31'd0, pass}, 32'd1);
        chk("t2_cycles", cycles, 32'd6);
        idle(10);
        chk("t2_frozen", cycles, 32'd6);

        // T3 FAIL then sticky
        do_reset();
        idle(3);
        step(BASE, 32'hBEEF_0007, 1'b1);
        chk("t3_state", {30'd0, state}, 32'd2);
        chk("t3_code", {16'd0, fail_code}, 32'h0000_0007);
        step(BASE, 32'd1, 1'b1);
        chk("t3_sticky", {30'd0, state}, 32'd2);

        // T4 watchdog and same-edge races
        do_reset();
        idle(TO + 5);
        chk("t4_timeout", {30'd0, state}, 32'd3);
        chk("t4_cycles", cycles, TO);
        do_reset();
        idle(TO - 1);
        step(BASE, 32'd1, 1'b1);
        chk("t4_race_pass", {30'd0, state}, 32'd1);
        chk("t4_race_cycles", cycles, TO);
        do_reset();
        idle(TO - 1);
        step(BASE, 32'd0, 1'b1);
        chk("t4_zero_write", {30'd0, state}, 32'd3);

        // T5 checkpoint, scratch, decode edges
        do_reset();
        for (int i = 0; i < 3; i++) step(BASE + 32'd4, 32'h0000_00A5, 1'b1);
        step(BASE + 32'd12, 32'h0000_1234, 1'b1);
        peek("t5_ckpt", BASE + 32'd4, 32'h0300_00A5, 1'b1);
        peek("t5_scratch", BASE + 32'd12, 32'h0000_1234, 1'b1);
        peek("t5_misaligned", BASE + 32'd2, 32'd0, 1'b0);
        peek("t5_outside", BASE + 32'd16, 32'd0, 1'b0);
        step(BASE + 32'd8, 32'hFFFF_FFFF, 1'b1);
        step(BASE + 32'd2, 32'hDEAD_0000, 1'b1);
        for (int i = 0; i < 300; i++) step(BASE + 32'd4, $urandom, 1'b1);
        step(BASE + 32'd4, 32'h1122_3344, 1'b1);
        peek("t5_ckpt_sat", BASE + 32'd4, 32'hFF22_3344, 1'b1);
        step(BASE, 32'd1, 1'b1);
        step(BASE + 32'd4, 32'h5555_5555, 1'b1);
        step(BASE + 32'd12, 32'h0000_ABCD, 1'b1);
        peek("t5_term_scratch", BASE + 32'd12, 32'h0000_ABCD, 1'b1);

        // T6 asynchronous reset between edges after PASS
        do_reset();
        idle(2);
        step(BASE, 32'd1, 1'b1);
        step(BASE + 32'd12, 32'h55, 1'b1);
        adr   = BASE + 32'd12;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_state", {30'd0, state}, 32'd0);
        chk("t6_pass", {31'd0, pass}, 32'd0);
        chk("t6_cycles", cycles, 32'd0);
        chk("t6_scratch", rd, 32'd0);
        model_reset();
        check_outs();
        @(negedge clk);
        reset = 1'b0;

        // Randomized runs against the model
        for (int r = 0; r < 20; r++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                step(rand_addr(), rand_data(), ($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
